// File: rtl/la_orevent_pkg.sv
// Shared constants and helpers for the la_orevent event collector.
// N is limited to LA_MAX_N by the masked OR-reduce helper.
package la_orevent_pkg;

  localparam int LA_EV_LEVEL = 0;
  localparam int LA_EV_EDGE  = 1;
  localparam int SYNC_STAGES = 2;
  localparam int LA_MAX_N    = 64;

  function automatic logic la_mask_or(
    input logic [LA_MAX_N-1:0] v,
    input logic [LA_MAX_N-1:0] m
  );
    return |(v & m);
  endfunction

endpackage

// File: rtl/la_orevent_sync.sv
// N-wide multi-flop synchronizer with async active-low reset.
// Used by la_orevent only when LA_OREVENT_SYNC_EN is defined.
module la_orevent_sync
  import la_orevent_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/la_orevent.sv
// Registered sticky event collector with masked OR output z.
// Define LA_OREVENT_SYNC_EN to add a 2-flop input synchronizer.
module la_orevent
  import la_orevent_pkg::*;
#(
  parameter int N    = 2,
  parameter int EDGE = LA_EV_EDGE,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pending,
  output logic [N-1:0] overflow,
  output logic         z
);

  localparam logic EDGE_MODE = (EDGE == LA_EV_EDGE);

  logic [N-1:0]        s;
  logic [N-1:0]        in_q;
  logic [N-1:0]        ev;
  logic [LA_MAX_N-1:0] pend_w;
  logic [LA_MAX_N-1:0] mask_w;

  if ($bits(PROP) == 0) begin : g_prop_empty
  end

`ifdef LA_OREVENT_SYNC_EN
  la_orevent_sync #(
    .N(N)
  ) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (in),
    .q      (s)
  );
`else
  assign s = in;
`endif

  // In level mode the history term is forced off, so ev follows s.
  assign ev = s & ~(in_q & {N{EDGE_MODE}});

  assign pend_w = LA_MAX_N'(pending);
  assign mask_w = LA_MAX_N'(mask);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      in_q     <= '0;
      pending  <= '0;
      overflow <= '0;
      z        <= 1'b0;
    end else begin
      in_q     <= s;
      pending  <= ev | (pending & ~clr);
      overflow <= (ev & pending & ~clr)
                | (overflow & ~clr);
      z        <= la_mask_or(pend_w, mask_w);
    end
  end

endmodule

// File: tb/tb_la_orevent.sv
// Directed bench: edge DUT (N=4) and level DUT (N=1).
// Expected latencies follow LA_OREVENT_SYNC_EN.
module tb_la_orevent;

`ifdef LA_OREVENT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] in_e, mask_e, clr_e;
  logic [3:0] pend_e, ovf_e;
  logic       z_e;

  logic       nreset_l;
  logic [0:0] in_l, mask_l, clr_l;
  logic [0:0] pend_l, ovf_l;
  logic       z_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  la_orevent #(
    .N(4), .EDGE(1)
  ) u_edge (
    .clk      (clk),
    .nreset   (nreset),
    .in       (in_e),
    .mask     (mask_e),
    .clr      (clr_e),
    .pending  (pend_e),
    .overflow (ovf_e),
    .z        (z_e)
  );

  la_orevent #(
    .N(1), .EDGE(0)
  ) u_lvl (
    .clk      (clk),
    .nreset   (nreset_l),
    .in       (in_l),
    .mask     (mask_l),
    .clr      (clr_l),
    .pending  (pend_l),
    .overflow (ovf_l),
    .z        (z_l)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset   = 1'b0;
    nreset_l = 1'b0;
    in_e     = 4'hF;
    mask_e   = 4'hF;
    clr_e    = 4'h0;
    in_l     = 1'b0;
    mask_l   = 1'b1;
    clr_l    = 1'b0;
    tick();
    tick();
    chk("rst_pend", 32'(pend_e), 32'h0);
    chk("rst_ovf",  32'(ovf_e),  32'h0);
    chk("rst_z",    32'(z_e),    32'h0);
    chk("rst_l_pend", 32'(pend_l), 32'h0);

    // 1: input high across reset release
    nreset   = 1'b1;
    nreset_l = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("t1_pend", 32'(pend_e), 32'hF);
    chk("t1_ovf",  32'(ovf_e),  32'h0);
    chk("t1_z0",   32'(z_e),    32'h0);
    tick();
    chk("t1_z1",   32'(z_e),    32'h1);

    in_e  = 4'h0;
    clr_e = 4'hF;
    repeat (LAT + 2) tick();
    clr_e = 4'h0;
    tick();
    chk("cln_pend", 32'(pend_e), 32'h0);
    chk("cln_ovf",  32'(ovf_e),  32'h0);
    chk("cln_z",    32'(z_e),    32'h0);

    // 2: edge capture and clear
    mask_e = 4'b0010;
    in_e   = 4'b0010;
    tick();
    in_e   = 4'h0;
    repeat (LAT) tick();
    chk("t2_pend", 32'(pend_e), 32'h2);
    chk("t2_z0",   32'(z_e),    32'h0);
    tick();
    chk("t2_z1",   32'(z_e),    32'h1);
    clr_e = 4'b0010;
    tick();
    clr_e = 4'h0;
    chk("t2_clr_pend", 32'(pend_e), 32'h0);
    chk("t2_clr_zlag", 32'(z_e),    32'h1);
    tick();
    chk("t2_clr_z", 32'(z_e), 32'h0);

    // 3: masking
    mask_e = 4'h0;
    in_e   = 4'b1000;
    tick();
    in_e   = 4'h0;
    repeat (LAT) tick();
    chk("t3_pend", 32'(pend_e), 32'h8);
    tick();
    chk("t3_zmask", 32'(z_e), 32'h0);
    mask_e = 4'b1000;
    tick();
    chk("t3_zunmask", 32'(z_e), 32'h1);
    clr_e  = 4'hF;
    tick();
    clr_e  = 4'h0;
    mask_e = 4'h0;
    tick();

    // 4: overflow
    in_e = 4'b0001;
    tick();
    in_e = 4'h0;
    tick();
    in_e = 4'b0001;
    tick();
    in_e = 4'h0;
    repeat (LAT) tick();
    chk("t4_pend", 32'(pend_e), 32'h1);
    chk("t4_ovf",  32'(ovf_e),  32'h1);
    clr_e = 4'b0001;
    tick();
    clr_e = 4'h0;
    chk("t4_clr_pend", 32'(pend_e), 32'h0);
    chk("t4_clr_ovf",  32'(ovf_e),  32'h0);

    // 5: event and clear in the same cycle
    in_e = 4'b0100;
    tick();
    in_e = 4'h0;
    repeat (LAT + 1) tick();
    chk("t5_pre", 32'(pend_e), 32'h4);
    in_e = 4'b0100;
    repeat (LAT) tick();
    clr_e = 4'b0100;
    tick();
    clr_e = 4'h0;
    chk("t5_pend", 32'(pend_e), 32'h4);
    chk("t5_ovf",  32'(ovf_e),  32'h0);
    in_e = 4'h0;

    // 6: level mode, held input, async reset
    in_l = 1'b1;
    repeat (LAT) tick();
    chk("t6_early", 32'(pend_l), 32'h0);
    tick();
    chk("t6_pend", 32'(pend_l), 32'h1);
    chk("t6_ovf0", 32'(ovf_l),  32'h0);
    tick();
    chk("t6_ovf1", 32'(ovf_l),  32'h1);
    chk("t6_z",    32'(z_l),    32'h1);
    clr_l = 1'b1;
    tick();
    clr_l = 1'b0;
    chk("t6_clr_pend", 32'(pend_l), 32'h1);
    chk("t6_clr_ovf",  32'(ovf_l),  32'h0);
    #2;
    nreset_l = 1'b0;
    #1;
    chk("t6_ar_pend", 32'(pend_l), 32'h0);
    chk("t6_ar_ovf",  32'(ovf_l),  32'h0);
    chk("t6_ar_z",    32'(z_l),    32'h0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
